// File: rtl/switch_bounce_gen_if.sv
// Command/line bundle between a switch requester and the bounce generator.
interface switch_bounce_gen_if;
  localparam int unsigned EDGE_W = 8;

  logic              cmd_valid;
  logic              cmd_level;
  logic              cmd_ready;
  logic              bounce_out;
  logic              busy;
  logic [EDGE_W-1:0] edge_cnt;

  modport master (
    output cmd_valid, cmd_level,
    input  cmd_ready, bounce_out, busy, edge_cnt
  );

  modport slave (
    input  cmd_valid, cmd_level,
    output cmd_ready, bounce_out, busy, edge_cnt
  );
endinterface

// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: clean first edge, LFSR-driven bounce window,
// then a stable settle hold before the next command is taken.
module switch_bounce_gen #(
  parameter int unsigned BOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SETTLE_CYCLES = 2_500_000,
  parameter int unsigned GLITCH_DIV    = 5_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  switch_bounce_gen_if.slave  bus
);

  localparam int unsigned BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PW = (GLITCH_DIV    > 1) ? $clog2(GLITCH_DIV)    : 1;
  localparam int unsigned EW = 8;

  localparam logic [15:0]   SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]   TAPS      = 16'hB400;
  localparam logic [BW-1:0] BCNT_INIT = BW'(BOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCNT_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_INIT = PW'(GLITCH_DIV - 1);
  localparam logic [EW-1:0] EDGE_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   lfsr;
  logic [BW-1:0] bcnt;
  logic [SW-1:0] scnt;
  logic [PW-1:0] pcnt;
  logic          target;
  logic          out_q;
  logic [EW-1:0] edge_q;

  logic          start_c;
  logic [EW-1:0] edge_inc_c;
  logic [15:0]   lfsr_nxt_c;
  logic          cmd_ready_c;
  logic          busy_c;

  // A real change is an accepted command whose level differs from the line.
  assign start_c    = (state == IDLE) && bus.cmd_valid && (bus.cmd_level != out_q);
  assign edge_inc_c = (edge_q == EDGE_MAX) ? edge_q : edge_q + EW'(1);
  assign lfsr_nxt_c = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

  // Free-running Galois LFSR, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= lfsr_nxt_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_c)      state_nxt = BOUNCE;
      BOUNCE:  if (bcnt == '0)   state_nxt = SETTLE;
      SETTLE:  if (scnt == '0)   state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_c = 1'b0;
    busy_c      = 1'b0;
    case (state)
      IDLE:           cmd_ready_c = 1'b1;
      BOUNCE, SETTLE: busy_c      = 1'b1;
      default:        cmd_ready_c = 1'b0;
    endcase
  end

  // Line, target, counters and edge count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= 1'b0;
      target <= 1'b0;
      edge_q <= '0;
      bcnt   <= '0;
      scnt   <= '0;
      pcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            target <= bus.cmd_level;
            out_q  <= bus.cmd_level;
            bcnt   <= BCNT_INIT;
            pcnt   <= PCNT_INIT;
            edge_q <= EW'(1);
          end
        end
        BOUNCE: begin
          if (bcnt == '0) begin
            out_q <= target;
            if (out_q != target) edge_q <= edge_inc_c;
            scnt  <= SCNT_INIT;
          end else begin
            bcnt <= bcnt - BW'(1);
            if (pcnt == '0) begin
              out_q <= lfsr[0];
              pcnt  <= PCNT_INIT;
              if (out_q != lfsr[0]) edge_q <= edge_inc_c;
            end else begin
              pcnt <= pcnt - PW'(1);
            end
          end
        end
        SETTLE: begin
          if (scnt != '0) scnt <= scnt - SW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.busy       = busy_c;
  assign bus.bounce_out = out_q;
  assign bus.edge_cnt   = edge_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Randomized bench for switch_bounce_gen against a cycle-index reference model.
module tb_switch_bounce_gen;

  localparam int unsigned B    = 16;
  localparam int unsigned S    = 8;
  localparam int unsigned D    = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int unsigned B2   = 600;
  localparam int unsigned S2   = 4;
  localparam int unsigned D2   = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  switch_bounce_gen_if bus ();
  switch_bounce_gen_if bus2 ();

  switch_bounce_gen #(.BOUNCE_CYCLES(B), .SETTLE_CYCLES(S), .GLITCH_DIV(D), .LFSR_SEED(SEED))
    dut (.clk(clk), .reset(reset), .bus(bus));

  switch_bounce_gen #(.BOUNCE_CYCLES(B2), .SETTLE_CYCLES(S2), .GLITCH_DIV(D2), .LFSR_SEED(SEED))
    dut_sat (.clk(clk), .reset(reset), .bus(bus2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Reference model state: k = clock edges elapsed since the accepting edge.
  logic        chk_en  = 1'b0;
  logic [15:0] m_lfsr  = SEED;
  logic        m_busy  = 1'b0;
  logic        m_out   = 1'b0;
  logic        m_tgt   = 1'b0;
  int          m_edges = 0;
  int          m_k     = 0;

  // Monitors: raw toggle count and an early-detect debouncer (32-cycle lockout).
  logic p_busy = 1'b0, p_out = 1'b0, aborted = 1'b1;
  int   mon = 0;
  logic db_out = 1'b0, db_ok = 1'b0;
  int   db_timer = 0, db_tog = 0;

  logic p_busy2 = 1'b0, p_out2 = 1'b0, aborted2 = 1'b1, sat_tgt = 1'b0;
  logic [7:0] p_edge2 = '0;
  int   mon2 = 0;

  task automatic model_set(input logic v);
    if (v != m_out) begin
      m_out = v;
      if (m_edges < 255) m_edges++;
    end
  endtask

  // Inputs change at negedge+1, so at each negedge they still hold the value
  // seen by the posedge just past; the model steps here, then compares.
  always @(negedge clk) begin
    if (reset) begin
      m_lfsr = SEED; m_busy = 1'b0; m_out = 1'b0; m_tgt = 1'b0; m_edges = 0; m_k = 0;
      aborted = 1'b1; mon = 0; db_out = 1'b0; db_timer = 0; db_tog = 0; db_ok = 1'b0;
      aborted2 = 1'b1; mon2 = 0;
    end else begin
      if (!m_busy) begin
        if (bus.cmd_valid && (bus.cmd_level != m_out)) begin
          m_busy = 1'b1; m_k = 0; m_tgt = bus.cmd_level; m_out = bus.cmd_level; m_edges = 1;
        end
      end else begin
        m_k++;
        if (m_k < int'(B)) begin
          if ((m_k % int'(D)) == 0) model_set(m_lfsr[0]);
        end else if (m_k == int'(B)) begin
          model_set(m_tgt);
        end
        if (m_k == int'(B + S)) m_busy = 1'b0;
      end
      m_lfsr = lfsr_step(m_lfsr);

      if (chk_en) begin
        check("bounce_out", 32'(bus.bounce_out), 32'(m_out));
        check("busy",       32'(bus.busy),       32'(m_busy));
        check("cmd_ready",  32'(bus.cmd_ready),  32'(!m_busy));
        check("edge_cnt",   32'(bus.edge_cnt),   32'(m_edges));
      end

      if (bus.busy && !p_busy) begin
        mon = 0; aborted = 1'b0; db_ok = (db_timer == 0); db_tog = 0;
      end
      if (bus.bounce_out != p_out) mon++;
      if (db_timer != 0) db_timer--;
      else if (bus.bounce_out != db_out) begin
        db_out = bus.bounce_out; db_timer = 31; db_tog++;
      end
      if (!bus.busy && p_busy && !aborted) begin
        check("edge_vs_monitor", 32'(bus.edge_cnt), 32'((mon > 255) ? 255 : mon));
        check("settled_level",   32'(bus.bounce_out), 32'(m_tgt));
        if (db_ok) begin
          check("debounce_once",  32'(db_tog), 32'd1);
          check("debounce_level", 32'(db_out), 32'(m_tgt));
        end
      end

      if (bus2.busy && !p_busy2) begin
        mon2 = 0; aborted2 = 1'b0;
      end
      if (bus2.bounce_out != p_out2) mon2++;
      if (bus2.busy && p_busy2)
        check("sat_no_wrap", 32'(bus2.edge_cnt >= p_edge2), 32'd1);
      if (!bus2.busy && p_busy2 && !aborted2) begin
        check("sat_edges", 32'(bus2.edge_cnt), 32'((mon2 > 255) ? 255 : mon2));
        check("sat_max",   32'(bus2.edge_cnt), 32'd255);
        check("sat_level", 32'(bus2.bounce_out), 32'(sat_tgt));
      end
    end
    p_busy  = bus.busy;  p_out  = bus.bounce_out;
    p_busy2 = bus2.busy; p_out2 = bus2.bounce_out; p_edge2 = bus2.edge_cnt;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic lvl);
    int n;
    n = 0;
    bus.cmd_level = lvl;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check("send_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 1000) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int idx, busy_n, n;
    logic [7:0] e0;
    bus.cmd_valid = 1'b0; bus.cmd_level = 1'b0;
    bus2.cmd_valid = 1'b0; bus2.cmd_level = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_out",   32'(bus.bounce_out), 32'd0);
    check("rst_busy",  32'(bus.busy),       32'd0);
    check("rst_ready", 32'(bus.cmd_ready),  32'd1);
    check("rst_edges", 32'(bus.edge_cnt),   32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // First command: clean edge, then the full busy window.
    bus.cmd_level = 1'b1; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("first_edge", 32'(bus.bounce_out), 32'd1);
    idx = 0; busy_n = 0;
    while (bus.busy && idx < 200) begin
      busy_n++;
      check("ready_low_busy", 32'(bus.cmd_ready), 32'd0);
      if (idx >= 16) check("hold_target", 32'(bus.bounce_out), 32'd1);
      tick();
      idx++;
    end
    check("busy_len", 32'(busy_n), 32'd24);

    // Same-level command is taken and dropped.
    e0 = bus.edge_cnt;
    bus.cmd_level = 1'b1; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("drop_out",   32'(bus.bounce_out), 32'd1);
    check("drop_busy",  32'(bus.busy),       32'd0);
    check("drop_edges", 32'(bus.edge_cnt),   32'(e0));
    check("drop_ready", 32'(bus.cmd_ready),  32'd1);

    // Command issued while busy waits for the first IDLE cycle.
    send(1'b0); wait_idle();
    send(1'b1);
    idx = 0;
    repeat (5) begin tick(); idx++; end
    bus.cmd_level = 1'b0; bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && idx < 200) begin tick(); idx++; end
    check("accept_cycle", 32'(idx), 32'd24);
    tick(); idx++;
    bus.cmd_valid = 1'b0;
    check("fall_cycle25", 32'(bus.bounce_out), 32'd0);
    wait_idle();

    // Random commands with random gaps and stray requests.
    for (int i = 0; i < 30; i++) begin
      send(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 10)) tick();
        bus.cmd_level = 1'($urandom_range(0, 1)); bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
      end
      repeat ($urandom_range(0, 40)) tick();
    end
    wait_idle();

    // Reset in the middle of a bounce window; the model restarts the LFSR.
    send(~bus.bounce_out);
    repeat (7) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_out",   32'(bus.bounce_out), 32'd0);
    check("mid_rst_busy",  32'(bus.busy),       32'd0);
    check("mid_rst_ready", 32'(bus.cmd_ready),  32'd1);
    check("mid_rst_edges", 32'(bus.edge_cnt),   32'd0);
    repeat (2) tick();
    reset = 1'b0;
    send(1'b1); wait_idle();
    send(1'b0); wait_idle();

    // Saturation instance: long bounce with a sample every cycle.
    sat_tgt = 1'b1;
    bus2.cmd_level = 1'b1; bus2.cmd_valid = 1'b1;
    tick();
    bus2.cmd_valid = 1'b0;
    check("sat_first_edge", 32'(bus2.bounce_out), 32'd1);
    n = 0;
    while (bus2.busy && n < 2000) begin tick(); n++; end
    check("sat_idle", 32'(bus2.busy), 32'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_bounce_gen.md
Name: switch_bounce_gen

Overview:
- Emulates a mechanical switch for on-board and simulation testing of the debounce FSMs.
- Takes a clean level-change command, drives a bouncing line (pseudo-random glitches from an LFSR) for a bounded window, then settles at the target level.
- Its output feeds the non-debounced input of a debouncer; it is the source end of that interface.

Parameters:
- BOUNCE_CYCLES, 1_000_000, length of the bounce window in clk cycles (10 ms at 100 MHz); must be >= 2.
- SETTLE_CYCLES, 2_500_000, stable hold after the bounce before a new command is accepted; must be >= 1.
- GLITCH_DIV, 5_000, cycles between successive random samples on the line; must be >= 1.
- LFSR_SEED, 16'hACE1, initial LFSR value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  request to move the switch
- cmd_level  input  1  target switch level
- cmd_ready  output  1  high when a command can be accepted
- bounce_out  output  1  emulated raw switch line (registered)
- busy  output  1  high during BOUNCE or SETTLE
- edge_cnt  output  8  number of bounce_out transitions in the current/last event, saturating at 255

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, bounce_out=0, target=0, edge_cnt=0, LFSR=seed, all counters 0.
  - cmd_ready=1 and busy=0 are decoded combinationally from the state.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances every cycle out of reset, regardless of state; sample bit is lfsr[0].
- States: IDLE, BOUNCE, SETTLE.
  - cmd_ready = (state==IDLE).
  - busy = (state!=IDLE).
- IDLE:
  - Handshake fires on an edge where cmd_valid && cmd_ready.
  - If cmd_level == bounce_out: command is accepted and dropped. State stays IDLE, edge_cnt is unchanged.
  - Else on that edge:
    - target<=cmd_level and bounce_out<=cmd_level (the first edge is clean and immediate, latency 1 cycle).
    - bcnt<=BOUNCE_CYCLES-1, pcnt<=GLITCH_DIV-1, edge_cnt<=1.
    - state<=BOUNCE.
- BOUNCE (occupies exactly BOUNCE_CYCLES cycles):
  - If bcnt==0:
    - bounce_out<=target; edge_cnt increments if this changes bounce_out.
    - scnt<=SETTLE_CYCLES-1, state<=SETTLE.
  - Else bcnt decrements, and:
    - If pcnt==0: bounce_out<=lfsr[0], pcnt<=GLITCH_DIV-1, edge_cnt increments (saturating) if the value changes.
    - Else pcnt decrements.
  - The line therefore holds target for at least GLITCH_DIV cycles after the initial edge.
- SETTLE (occupies exactly SETTLE_CYCLES cycles):
  - bounce_out holds target.
  - If scnt==0, state<=IDLE; else scnt decrements.
- Timing rules:
  - Total busy time per real change is BOUNCE_CYCLES+SETTLE_CYCLES cycles.
  - The next command is accepted on the first IDLE cycle.
- cmd_valid while busy is ignored (not queued). The requester must hold cmd_valid until it sees cmd_ready.
- edge_cnt holds its value through IDLE until the next real change.
- Reset mid-operation: returns immediately to the reset values, with no residual glitches on bounce_out.
- Illegal state encoding goes to IDLE.
- Counter widths are $clog2 of the respective parameter (minimum 1 bit). All comparisons are against 0; no overflow is possible.

Test Plan:
(Use B=16, S=8, D=2, seed 16'hACE1.)
- Reset, then cmd_valid=1, cmd_level=1 for one cycle:
  - bounce_out=1 on the next cycle.
  - busy=1 for exactly 24 cycles; cmd_ready=0 during those cycles.
  - bounce_out=1 from cycle 16 onward.
  - edge_cnt equals the toggle count recorded by a bench monitor.
- While in IDLE with bounce_out=1, issue cmd_level=1: bounce_out, busy and edge_cnt are unchanged; cmd_ready stays 1.
- Issue cmd_level=0 at cycle 5 of a busy period:
  - The command is ignored.
  - Holding cmd_valid makes it accepted on the first IDLE cycle (cycle 24), and bounce_out falls on cycle 25.
- Assert reset at cycle 7 of BOUNCE:
  - bounce_out=0, busy=0, cmd_ready=1, edge_cnt=0 in the same cycle.
  - The LFSR output sequence restarts at the seed.
- D=1, B=600: edge_cnt saturates at 255 and never wraps; bounce_out still ends at target.
- Loop the output into the early-detect debouncer with TIMER_WIDTH=5: the debounced output changes exactly once per command.
